// File: rtl/led_blink_sequencer.sv
// Turns single-cycle event pulses into LED blinks of fixed on-time and dark gap,
// queueing events that arrive mid-blink in a saturating pending counter.
module led_blink_sequencer #(
  parameter int CLK_FREQ   = 12000000,
  parameter int ON_MS      = 100,
  parameter int OFF_MS     = 100,
  parameter int PEND_W     = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              event_pulse,
  input  logic              clear,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int DIV    = CLK_FREQ / 1000;
  localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PH_MAX = (ON_MS > OFF_MS) ? ON_MS : OFF_MS;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PRE_W-1:0]  PRE_TOP  = PRE_W'(DIV - 1);
  localparam logic [PH_W-1:0]   ON_LAST  = PH_W'(ON_MS - 1);
  localparam logic [PH_W-1:0]   OFF_LAST = PH_W'(OFF_MS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [PRE_W-1:0]  pre;
  logic              tick;
  logic [PH_W-1:0]   phase, phase_next;
  logic [PEND_W-1:0] pending_next;
  logic              overflow_next;
  logic              want;
  logic              start;

  // Free-running ms prescaler; only rst realigns it, so clear keeps tick phase.
  assign tick = (pre == PRE_TOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      led      <= ACTIVE_LOW;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      phase    <= phase_next;
      pending  <= pending_next;
      overflow <= overflow_next;
      led      <= (state_next == ON) ^ ACTIVE_LOW;
      busy     <= (state_next != IDLE);
    end
  end

  assign want = (pending != '0) || event_pulse;

  always_comb begin
    state_next    = state;
    phase_next    = phase;
    pending_next  = pending;
    overflow_next = 1'b0;
    start         = 1'b0;

    case (state)
      IDLE: begin
        if (want) start = 1'b1;
      end
      ON: begin
        if (tick) begin
          if (phase == ON_LAST) begin
            state_next = GAP;
            phase_next = '0;
          end else begin
            phase_next = phase + 1'b1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (phase == OFF_LAST) begin
            if (want) begin
              start = 1'b1;
            end else begin
              state_next = IDLE;
              phase_next = '0;
            end
          end else begin
            phase_next = phase + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        phase_next = '0;
      end
    endcase

    // A start consumes one event: the incoming pulse if present, else a queued one.
    if (start) begin
      state_next   = ON;
      phase_next   = '0;
      pending_next = event_pulse ? pending : (pending - 1'b1);
    end else if (event_pulse) begin
      if (pending == PEND_MAX) begin
        overflow_next = 1'b1;
      end else begin
        pending_next = pending + 1'b1;
      end
    end

    if (clear) begin
      state_next    = IDLE;
      phase_next    = '0;
      pending_next  = '0;
      overflow_next = 1'b0;
    end
  end

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Directed bench for led_blink_sequencer: 1 ms tick every 10 clocks, 3-tick blink, 2-tick gap.
module tb_led_blink_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       event_pulse;
  logic       clear;
  logic       led;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int blinks = 0;
  int ovf_cnt = 0;
  bit led_q;

  led_blink_sequencer #(
    .CLK_FREQ(10000),
    .ON_MS(3),
    .OFF_MS(2),
    .PEND_W(2),
    .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .event_pulse(event_pulse),
    .clear(clear),
    .led(led),
    .busy(busy),
    .pending(pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (led && !led_q) blinks++;
    led_q = led;
    if (overflow) ovf_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_led"}, 32'(led), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_pending"}, 32'(pending), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
  endtask

  initial begin
    int base;
    int dur;
    int n;

    rst = 1'b1;
    event_pulse = 1'b0;
    clear = 1'b0;
    cyc(3);
    chk_idle_outputs("reset");
    rst = 1'b0;

    // Scenario 1: single event, prescaler phase 0 (t counts edges after reset)
    base = blinks;
    event_pulse = 1'b1;
    cyc(1);                        // t=1
    event_pulse = 1'b0;
    chk("s1_led_on", 32'(led), 1);
    chk("s1_busy_on", 32'(busy), 1);
    chk("s1_pending", 32'(pending), 0);
    cyc(28);                       // t=29
    chk("s1_led_last_on", 32'(led), 1);
    cyc(1);                        // t=30
    chk("s1_led_gap", 32'(led), 0);
    chk("s1_busy_gap", 32'(busy), 1);
    cyc(19);                       // t=49
    chk("s1_busy_gap_end", 32'(busy), 1);
    cyc(1);                        // t=50
    chk_idle_outputs("s1_idle");
    chk("s1_blinks", 32'(blinks - base), 1);

    // Scenario 2: one event queued during ON, one during GAP
    base = blinks;
    event_pulse = 1'b1;
    cyc(1);                        // t=51
    event_pulse = 1'b0;
    cyc(3);                        // t=54
    event_pulse = 1'b1;
    cyc(1);                        // t=55
    event_pulse = 1'b0;
    chk("s2_pending1", 32'(pending), 1);
    cyc(25);                       // t=80
    chk("s2_gap1_led", 32'(led), 0);
    cyc(5);                        // t=85
    event_pulse = 1'b1;
    cyc(1);                        // t=86
    event_pulse = 1'b0;
    chk("s2_pending2", 32'(pending), 2);
    cyc(13);                       // t=99
    chk("s2_busy_before_restart", 32'(busy), 1);
    cyc(1);                        // t=100
    chk("s2_restart2_led", 32'(led), 1);
    chk("s2_restart2_busy", 32'(busy), 1);
    chk("s2_restart2_pending", 32'(pending), 1);
    cyc(50);                       // t=150
    chk("s2_restart3_led", 32'(led), 1);
    chk("s2_restart3_pending", 32'(pending), 0);
    cyc(49);                       // t=199
    chk("s2_busy_last_gap", 32'(busy), 1);
    cyc(1);                        // t=200
    chk_idle_outputs("s2_idle");
    chk("s2_blinks", 32'(blinks - base), 3);

    // Scenario 4: event coincides with GAP completion, pending=0
    base = blinks;
    event_pulse = 1'b1;
    cyc(1);                        // t=201
    event_pulse = 1'b0;
    cyc(48);                       // t=249
    chk("s4_gap_led", 32'(led), 0);
    event_pulse = 1'b1;
    cyc(1);                        // t=250
    event_pulse = 1'b0;
    chk("s4_reon_led", 32'(led), 1);
    chk("s4_reon_busy", 32'(busy), 1);
    chk("s4_reon_pending", 32'(pending), 0);
    cyc(50);                       // t=300
    chk_idle_outputs("s4_idle");
    chk("s4_blinks", 32'(blinks - base), 2);

    // Scenario 3: five back-to-back events during ON saturate the queue
    base = blinks;
    event_pulse = 1'b1;
    cyc(1);                        // t=301
    n = ovf_cnt;
    cyc(5);                        // t=306
    event_pulse = 1'b0;
    chk("s3_pending_sat", 32'(pending), 3);
    cyc(1);                        // t=307
    chk("s3_overflow_cleared", 32'(overflow), 0);
    chk("s3_overflow_pulses", 32'(ovf_cnt - n), 2);
    cyc(93);                       // t=400
    chk("s3_third_led", 32'(led), 1);
    chk("s3_third_pending", 32'(pending), 1);
    cyc(100);                      // t=500
    chk_idle_outputs("s3_idle");
    chk("s3_blinks", 32'(blinks - base), 4);

    // Scenario 5: clear mid-ON with pending=2 and a coincident event
    event_pulse = 1'b1;
    cyc(3);                        // t=503
    event_pulse = 1'b0;
    chk("s5_pending2", 32'(pending), 2);
    cyc(2);                        // t=505
    chk("s5_led_before_clear", 32'(led), 1);
    n = ovf_cnt;
    clear = 1'b1;
    event_pulse = 1'b1;
    cyc(1);                        // t=506
    clear = 1'b0;
    event_pulse = 1'b0;
    chk_idle_outputs("s5_clear");
    base = blinks;
    cyc(100);                      // t=606
    chk("s5_still_idle", 32'(busy), 0);
    chk("s5_no_blinks", 32'(blinks - base), 0);
    chk("s5_no_overflow", 32'(ovf_cnt - n), 0);

    // Scenario 6: rst mid-GAP with pending=1, then a normal blink
    event_pulse = 1'b1;
    cyc(1);                        // t=607, ON
    cyc(1);                        // t=608
    event_pulse = 1'b0;
    chk("s6_pending1", 32'(pending), 1);
    cyc(27);                       // t=635, GAP
    chk("s6_gap_led", 32'(led), 0);
    chk("s6_gap_busy", 32'(busy), 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk_idle_outputs("s6_reset");
    event_pulse = 1'b1;
    cyc(1);
    event_pulse = 1'b0;
    chk("s6_led_on", 32'(led), 1);
    dur = 0;
    while (led && dur < 100) begin
      cyc(1);
      dur++;
    end
    chk("s6_on_cycles", 32'(dur), 29);
    chk("s6_on_in_window", 32'((dur > 20) && (dur <= 30)), 1);
    n = 0;
    while (busy && n < 100) begin
      cyc(1);
      n++;
    end
    chk("s6_gap_cycles", 32'(n), 20);
    chk_idle_outputs("s6_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
